// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: default widths, the
// word-count limit and the state encoding.
package inst_loader_pkg;

  // Default instruction memory geometry (1024 x 32-bit words).
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WORDS  = 1 << ADDR_W_DEF;

  // Loader state encoding, kept as plain constants so older code that
  // compares raw state bits keeps working.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // True when a load may be (re)started from the given state.
  function automatic logic is_restartable(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/inst_loader.sv
// Instruction loader: streams words from a valid/ready source into the
// instruction memory, reads them back to confirm the running checksum, and
// holds the processor frozen until the image is known to be good.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // Largest legal word count: the whole memory.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [DATA_W-1:0] checksum_reg;
  logic [DATA_W-1:0] verify_sum_reg;

  logic              start_ok;
  logic              range_ok;
  logic              transfer;
  logic              wr_last;
  logic              rd_last;
  logic [DATA_W-1:0] verify_sum_new;

  assign start_ok       = start && is_restartable(state_reg);
  assign range_ok       = (word_count != '0) && (word_count <= MAX_CNT);
  // Reset kills any handshake in the same cycle so nothing is written.
  assign transfer       = (state_reg == ST_LOAD) && in_valid && !reset;
  // Pointers are compared against count-1 at full width, so a full-memory
  // load ends at the top address and the pointer wrap is harmless.
  assign wr_last        = ({1'b0, wr_ptr_reg} == (count_reg - 1'b1));
  assign rd_last        = ({1'b0, rd_ptr_reg} == (count_reg - 1'b1));
  assign verify_sum_new = verify_sum_reg + imem_rdata;

  // Next-state selection for the load / verify sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok) begin
          state_next = range_ok ? ST_LOAD : ST_ERROR;
        end
      end
      ST_LOAD: begin
        if (transfer && wr_last) begin
          state_next = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (rd_last) begin
          state_next = (verify_sum_new == checksum_reg) ? ST_DONE : ST_ERROR;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, pointers and running sums.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      checksum_reg   <= '0;
      verify_sum_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // A rejected start leaves the previous checksum visible.
          if (start_ok && range_ok) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= word_count;
            checksum_reg   <= '0;
            verify_sum_reg <= '0;
          end
        end
        ST_LOAD: begin
          if (transfer) begin
            wr_ptr_reg   <= wr_ptr_reg + 1'b1;
            checksum_reg <= checksum_reg + in_data;
          end
        end
        ST_VERIFY: begin
          rd_ptr_reg     <= rd_ptr_reg + 1'b1;
          verify_sum_reg <= verify_sum_new;
        end
        default: ;
      endcase
    end
  end

  // Memory port and handshake: writes go straight through in the accepting
  // cycle; read-back walks rd_ptr; elsewhere the port is parked at zero.
  always_comb begin
    in_ready   = (state_reg == ST_LOAD) && !reset;
    imem_we    = transfer;
    imem_addr  = '0;
    imem_wdata = '0;
    if (state_reg == ST_LOAD) begin
      imem_addr  = wr_ptr_reg;
      imem_wdata = in_data;
    end else if (state_reg == ST_VERIFY) begin
      imem_addr  = rd_ptr_reg;
    end
  end

  // Status flags derived from the current state.
  always_comb begin
    cpu_hold = (state_reg != ST_DONE);
    busy     = (state_reg == ST_LOAD) || (state_reg == ST_VERIFY);
    done     = (state_reg == ST_DONE);
    error    = (state_reg == ST_ERROR);
    checksum = checksum_reg;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomised self-checking bench for inst_loader with a behavioural memory
// and a reference model built from word lists and plain sums.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [DW-1:0] imem_rdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  inst_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clock = ~clock;

  // Behavioural instruction memory with optional read-back corruption at 1.
  logic [DW-1:0] mem [NW];
  logic          mem_init = 1'b1;
  logic          corrupt  = 1'b0;
  int unsigned   wr_cnt   = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'hDEAD_0000 | i;
    end else if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_cnt         <= wr_cnt + 1;
      last_wr_addr   <= imem_addr;
    end
  end

  assign imem_rdata = (corrupt && imem_addr == 1) ? ~mem[imem_addr] : mem[imem_addr];

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] words [NW];
  logic [DW-1:0] last_sum = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Run one complete load of words[0..cnt-1] and check it against the model.
  // gap_mode: 0 continuous, 1 valid every other cycle, 2 random gaps.
  task automatic run_load(input int cnt, input int gap_mode, input bit corr,
                          input bit poke_start, input string tag);
    logic [DW-1:0] sum;
    int idx, cyc, vc, bad_port, bad_mem;
    int unsigned base_wr;
    bit v, exp_ok;
    sum = '0;
    for (int i = 0; i < cnt; i++) sum += words[i];
    exp_ok   = !(corr && cnt > 1);
    corrupt  = corr;
    idx      = 0;
    cyc      = 0;
    bad_port = 0;
    start      = 1'b1;
    word_count = (AW + 1)'(cnt);
    tick();
    start = 1'b0;
    check({tag, " busy_load"}, busy, 1);
    base_wr = wr_cnt;
    while (idx < cnt && cyc < 8 * cnt + 20) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? words[idx] : $urandom;
      if (poke_start && cyc == 1) begin
        start      = 1'b1;
        word_count = '0;
      end else begin
        start = 1'b0;
      end
      #1;
      if (in_ready !== 1'b1) bad_port++;
      if (imem_we !== v) bad_port++;
      if (v && (imem_addr !== AW'(idx) || imem_wdata !== words[idx])) bad_port++;
      @(posedge clock);
      #1;
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, " words_accepted"}, idx, cnt);
    check({tag, " port_errors"}, bad_port, 0);
    check({tag, " ready_after_last"}, in_ready, 0);
    check({tag, " we_in_verify"}, imem_we, 0);
    vc = 0;
    while (!(done || error) && vc < cnt + 10) begin
      tick();
      vc++;
    end
    check({tag, " verify_cycles"}, vc, cnt);
    check({tag, " write_count"}, wr_cnt - base_wr, cnt);
    bad_mem = 0;
    for (int i = 0; i < cnt; i++) if (mem[i] !== words[i]) bad_mem++;
    check({tag, " mem_contents"}, bad_mem, 0);
    check({tag, " done"}, done, exp_ok);
    check({tag, " error"}, error, !exp_ok);
    check({tag, " cpu_hold"}, cpu_hold, !exp_ok);
    check({tag, " checksum"}, checksum, sum);
    last_sum = sum;
    $display("load %s: count=%0d gap=%0d corrupt=%0d sum=%08h done=%0d error=%0d",
             tag, cnt, gap_mode, corr, sum, done, error);
  endtask

  // A start with an out-of-range count goes straight to ERROR without writing.
  task automatic run_bad(input int cnt, input string tag);
    int unsigned base_wr;
    base_wr    = wr_cnt;
    start      = 1'b1;
    word_count = (AW + 1)'(cnt);
    tick();
    start = 1'b0;
    check({tag, " error"}, error, 1);
    check({tag, " done"}, done, 0);
    check({tag, " busy"}, busy, 0);
    tick();
    check({tag, " no_write"}, wr_cnt - base_wr, 0);
    check({tag, " checksum_held"}, checksum, last_sum);
    $display("bad start %s: count=%0d error=%0d", tag, cnt, error);
  endtask

  initial begin
    logic [DW-1:0] keep2;
    int cnt;
    reset      = 1'b1;
    start      = 1'b0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) tick();
    mem_init = 1'b0;
    check("rst in_ready", in_ready, 0);
    check("rst imem_we", imem_we, 0);
    reset = 1'b0;
    #1;
    check("rst imem_addr", imem_addr, 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("rst cpu_hold", cpu_hold, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst checksum", checksum, 0);
    $display("reset: cpu_hold=%0d checksum=%08h", cpu_hold, checksum);

    // Three MIPS instructions, continuous then gapped.
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_0007;
    words[2] = 32'h0109_5020;
    run_load(3, 0, 1'b0, 1'b0, "prog3_cont");
    run_load(3, 1, 1'b0, 1'b1, "prog3_gap");

    run_bad(0, "count0");
    run_bad(1025, "count1025");

    run_load(3, 0, 1'b1, 1'b0, "prog3_corrupt");

    // Reset after two of four words.
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    keep2      = mem[2];
    start      = 1'b1;
    word_count = 11'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
    end
    reset    = 1'b1;
    in_data  = words[2];
    #1;
    check("midrst we_blocked", imem_we, 0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst cpu_hold", cpu_hold, 1);
    check("midrst checksum", checksum, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst mem0", mem[0], words[0]);
    check("midrst mem1", mem[1], words[1]);
    check("midrst mem2", mem[2], keep2);
    $display("mid-load reset: cpu_hold=%0d checksum=%08h", cpu_hold, checksum);
    last_sum = '0;
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    run_load(2, 0, 1'b0, 1'b0, "after_rst");

    // Randomised loads.
    for (int t = 0; t < 12; t++) begin
      cnt = $urandom_range(1, 48);
      for (int i = 0; i < cnt; i++) words[i] = $urandom;
      run_load(cnt, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 1) == 1, $sformatf("rand%0d", t));
    end

    // Full-memory load of all ones.
    for (int i = 0; i < NW; i++) words[i] = 32'hFFFF_FFFF;
    run_load(NW, 0, 1'b0, 1'b0, "full");
    check("full last_addr", last_wr_addr, NW - 1);
    check("full checksum_const", checksum, 32'hFFFF_FC00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
